// File: rtl/fb_rect_writer.sv
// Rectangle fill engine: streams one grayscale pixel write per cycle in raster order into a framebuffer RAM.
// Optional bounds clipping against H_RES/V_RES is compiled in with macro FB_CLIP_EN.
module fb_rect_writer #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int ADDR_W = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [9:0]        cmd_x,
  input  logic [9:0]        cmd_y,
  input  logic [9:0]        cmd_w,
  input  logic [9:0]        cmd_h,
  input  logic [7:0]        cmd_color,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  localparam logic [31:0]       PITCH_BITS = 32'(H_RES);
  localparam logic [ADDR_W-1:0] PITCH      = ADDR_W'(H_RES);

  state_t            state_q, state_d;
  logic              rst_q;
  logic [ADDR_W-1:0] x_q, row_base_q, addr_q;
  logic [9:0]        w_q, h_q, col_q, row_q;
  logic [7:0]        color_q;
  logic [9:0]        eff_w, eff_h;
  logic              accept, last_col, last_row;

  // y*H_RES as a sum of shifted copies of y; H_RES is constant so this folds into a few adders.
  function automatic logic [ADDR_W-1:0] row_base_of(input logic [9:0] y);
    logic [ADDR_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < 32; i++) begin
      if (PITCH_BITS[i]) acc = acc + (ADDR_W'(y) << i);
    end
    return acc;
  endfunction

  always_comb begin
    eff_w = cmd_w;
    eff_h = cmd_h;
`ifdef FB_CLIP_EN
    if ({22'd0, cmd_x} >= 32'(H_RES))
      eff_w = 10'd0;
    else if ({22'd0, cmd_w} > 32'(H_RES) - {22'd0, cmd_x})
      eff_w = 10'(32'(H_RES) - {22'd0, cmd_x});
    if ({22'd0, cmd_y} >= 32'(V_RES))
      eff_h = 10'd0;
    else if ({22'd0, cmd_h} > 32'(V_RES) - {22'd0, cmd_y})
      eff_h = 10'(32'(V_RES) - {22'd0, cmd_y});
`endif
  end

  assign last_col = (col_q == w_q - 10'd1);
  assign last_row = (row_q == h_q - 10'd1);

  always_comb begin
    state_d   = state_q;
    cmd_ready = (state_q == IDLE) && !rst_q;
    mem_we    = (state_q == FILL);
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    mem_addr  = addr_q;
    mem_wdata = color_q;
    accept    = cmd_valid && cmd_ready;
    case (state_q)
      IDLE: if (accept) state_d = (eff_w == 10'd0 || eff_h == 10'd0) ? DONE : FILL;
      FILL: if (last_col && last_row) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // rst_q holds cmd_ready low for the cycle following a reset edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rst_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      rst_q   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q        <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
      w_q        <= '0;
      h_q        <= '0;
      col_q      <= '0;
      row_q      <= '0;
      color_q    <= '0;
    end else if (accept) begin
      x_q        <= ADDR_W'(cmd_x);
      w_q        <= eff_w;
      h_q        <= eff_h;
      color_q    <= cmd_color;
      col_q      <= '0;
      row_q      <= '0;
      row_base_q <= row_base_of(cmd_y);
      addr_q     <= row_base_of(cmd_y) + ADDR_W'(cmd_x);
    end else if (state_q == FILL) begin
      if (last_col) begin
        col_q      <= '0;
        row_q      <= row_q + 10'd1;
        row_base_q <= row_base_q + PITCH;
        addr_q     <= row_base_q + PITCH + x_q;
      end else begin
        col_q  <= col_q + 10'd1;
        addr_q <= addr_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fb_rect_writer.sv
// Directed bench for fb_rect_writer; outputs sampled on the falling edge, inputs changed there too.
module tb_fb_rect_writer;

  localparam int ADDR_W = 19;

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [9:0]        cmd_x, cmd_y, cmd_w, cmd_h;
  logic [7:0]        cmd_color;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_we, busy, done;

  int tests  = 0;
  int failed = 0;

  fb_rect_writer #(.H_RES(640), .V_RES(480), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_color(cmd_color),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Present a command for exactly one edge, leaving the bench at the falling edge after it.
  task automatic issue(input logic [9:0] x, input logic [9:0] y, input logic [9:0] w,
                       input logic [9:0] h, input logic [7:0] c);
    cmd_x = x; cmd_y = y; cmd_w = w; cmd_h = h; cmd_color = c;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  int exp35 [6] = '{650, 651, 652, 1290, 1291, 1292};
  int wq[$];
  bit got_done;
  bit saw_bad;

  initial begin
    reset = 1'b1; cmd_valid = 1'b0;
    cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;

    // Reset held three cycles
    @(negedge clk);
    chk("rst_ready_low", 32'(cmd_ready), 0);
    chk("rst_addr_zero", 32'(mem_addr), 0);
    chk("rst_wdata_zero", 32'(mem_wdata), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(cmd_ready), 1);
    chk("post_rst_we", 32'(mem_we), 0);
    chk("post_rst_done", 32'(done), 0);
    chk("post_rst_busy", 32'(busy), 0);

    // Single pixel
    issue(10'd3, 10'd2, 10'd1, 10'd1, 8'hAA);
    chk("px_we", 32'(mem_we), 1);
    chk("px_addr", 32'(mem_addr), 1283);
    chk("px_data", 32'(mem_wdata), 32'hAA);
    chk("px_busy", 32'(busy), 1);
    chk("px_ready", 32'(cmd_ready), 0);
    @(negedge clk);
    chk("px_done", 32'(done), 1);
    chk("px_done_we", 32'(mem_we), 0);
    chk("px_done_busy", 32'(busy), 1);
    @(negedge clk);
    chk("px_done_pulse", 32'(done), 0);
    chk("px_idle_ready", 32'(cmd_ready), 1);
    chk("px_idle_busy", 32'(busy), 0);

    // 3x2 fill with an intruding command mid-fill
    issue(10'd10, 10'd1, 10'd3, 10'd2, 8'h55);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("f32_we%0d", k), 32'(mem_we), 1);
      chk($sformatf("f32_addr%0d", k), 32'(mem_addr), 32'(exp35[k]));
      chk($sformatf("f32_data%0d", k), 32'(mem_wdata), 32'h55);
      chk($sformatf("f32_ready%0d", k), 32'(cmd_ready), 0);
      if (k == 2) begin
        cmd_x = 10'd0; cmd_y = 10'd0; cmd_w = 10'd1; cmd_h = 10'd1; cmd_color = 8'hFF;
        cmd_valid = 1'b1;
      end
      if (k == 3) cmd_valid = 1'b0;
      @(negedge clk);
    end
    chk("f32_done", 32'(done), 1);
    chk("f32_done_we", 32'(mem_we), 0);
    @(negedge clk);
    chk("f32_after_done", 32'(done), 0);
    chk("f32_after_we", 32'(mem_we), 0);
    chk("f32_ready_again", 32'(cmd_ready), 1);

    // Zero-size command accepted in the first idle cycle after DONE
    issue(10'd5, 10'd5, 10'd0, 10'd5, 8'h77);
    chk("zero_we", 32'(mem_we), 0);
    chk("zero_done", 32'(done), 1);
    @(negedge clk);
    chk("zero_we2", 32'(mem_we), 0);
    chk("zero_ready", 32'(cmd_ready), 1);

    // Bottom-right corner: clipped or wrapped-through
    issue(10'd638, 10'd479, 10'd4, 10'd2, 8'h3C);
    wq = {};
    got_done = 1'b0;
    for (int c = 0; c < 30 && !got_done; c++) begin
      if (mem_we) wq.push_back(int'(mem_addr));
      if (done) got_done = 1'b1;
      @(negedge clk);
    end
    chk("clip_done_seen", 32'(got_done), 1);
`ifdef FB_CLIP_EN
    chk("clip_count", 32'(wq.size()), 2);
    if (wq.size() == 2) begin
      chk("clip_a0", 32'(wq[0]), 307198);
      chk("clip_a1", 32'(wq[1]), 307199);
    end
`else
    chk("clip_count", 32'(wq.size()), 8);
    if (wq.size() == 8) begin
      for (int k = 0; k < 8; k++)
        chk($sformatf("noclip_a%0d", k), 32'(wq[k]),
            32'((k < 4) ? 307198 + k : 307838 + (k - 4)));
    end
`endif

    // Reset during the third write of a 4x4 fill
    issue(10'd0, 10'd0, 10'd4, 10'd4, 8'h11);
    @(negedge clk);
    @(negedge clk);
    chk("abort_w3_we", 32'(mem_we), 1);
    chk("abort_w3_addr", 32'(mem_addr), 2);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_we", 32'(mem_we), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_ready", 32'(cmd_ready), 0);
    chk("abort_addr", 32'(mem_addr), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_ready_after", 32'(cmd_ready), 1);
    saw_bad = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (done || mem_we) saw_bad = 1'b1;
      @(negedge clk);
    end
    chk("abort_quiet", 32'(saw_bad), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/fb_rect_writer.md
FB_RECT_WRITER -- requirements
Module: fb_rect_writer

Interface
REQ-001 SHALL have parameter H_RES, default 640, frame width in pixels and row pitch of the framebuffer.
REQ-002 SHALL have parameter V_RES, default 480, frame height in pixels.
REQ-003 SHALL have parameter ADDR_W, default 19, framebuffer address width.
REQ-004 SHALL have port clk  input  1  single clock; all logic is rising-edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port cmd_valid  input  1  fill command present.
REQ-007 SHALL have port cmd_ready  output  1  block can accept a command.
REQ-008 SHALL have ports cmd_x, cmd_y, cmd_w, cmd_h  input  10 each  rectangle origin and size in pixels.
REQ-009 SHALL have port cmd_color  input  8  grayscale fill value.
REQ-010 SHALL have port mem_addr  output  ADDR_W  framebuffer RAM write address.
REQ-011 SHALL have port mem_wdata  output  8  framebuffer RAM write data.
REQ-012 SHALL have port mem_we  output  1  framebuffer RAM write enable.
REQ-013 SHALL have port busy  output  1  fill in progress.
REQ-014 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-015 SHALL implement FSM IDLE -> FILL -> DONE -> IDLE.
REQ-016 SHALL assert cmd_ready only in IDLE; a command is accepted on cmd_valid && cmd_ready, and all cmd_* fields are registered at that edge.
REQ-017 SHALL ignore cmd_valid outside IDLE; no queuing.
REQ-018 SHALL, on acceptance with effective w == 0 or h == 0, go IDLE -> DONE and issue no writes.
REQ-019 SHALL otherwise enter FILL and issue the first write in the cycle after acceptance.
REQ-020 SHALL issue exactly one write per FILL cycle: mem_we = 1, mem_wdata = registered color, mem_addr = row_base + col.
REQ-021 SHALL traverse raster order: col runs from x to x+w-1; the row then advances, row_base increases by H_RES, and col reloads to x.
REQ-022 SHALL compute the initial row_base as y*H_RES using shift-add (y<<9 + y<<7 for 640), and SHALL add the pitch incrementally per row (no runtime multiplier).
REQ-023 SHALL truncate address arithmetic to ADDR_W bits.
REQ-024 SHALL take exactly w*h FILL cycles, then spend one DONE cycle with done = 1, then return to IDLE.
REQ-025 SHALL drive busy = 1 in FILL and DONE; mem_we = 0 in IDLE and DONE.
REQ-026 SHALL accept a new command in the first IDLE cycle after DONE (back-to-back gap of 1 cycle).

Reset
REQ-027 SHALL, while reset is high at a clock edge, force: state = IDLE, mem_we = 0, done = 0, busy = 0, mem_addr = 0, mem_wdata = 0, cmd_ready = 0.
REQ-028 SHALL abort a fill when reset is asserted mid-FILL: no further writes after that edge, and no done pulse.
REQ-029 SHALL assert cmd_ready in the first cycle after reset deasserts.

Configuration
REQ-030 SHALL compile bounds clipping under macro FB_CLIP_EN.
REQ-031 With FB_CLIP_EN defined, SHALL compute the effective w at acceptance as 0 if x >= H_RES, else min(w, H_RES-x); h SHALL be clipped likewise against V_RES.
REQ-032 Without FB_CLIP_EN, SHALL use raw w and h; out-of-frame pixels SHALL be written at computed (truncated) addresses.

Verification
REQ-033 SHALL verify reset: hold reset 3 cycles, then release -> cmd_ready = 1, mem_we = 0, done = 0, busy = 0.
REQ-034 SHALL verify a single pixel: x=3, y=2, w=1, h=1, color=0xAA -> one write with addr 1283, data 0xAA; done pulses in the next cycle.
REQ-035 SHALL verify a 3x2 fill: x=10, y=1, color=0x55 -> addrs 650, 651, 652, 1290, 1291, 1292 on consecutive cycles; cmd_ready = 0 throughout; done follows; a second cmd_valid during the fill is ignored.
REQ-036 SHALL verify a zero-size command: w=0, h=5 -> no mem_we; done = 1 in the cycle after acceptance.
REQ-037 SHALL verify clipping: x=638, y=479, w=4, h=2 -> with FB_CLIP_EN, writes only 307198 and 307199; without it, 8 writes at 307198-307201 and 307838-307841.
REQ-038 SHALL verify reset mid-fill: assert reset on the 3rd write of a 4x4 fill -> mem_we = 0 from the next edge, no done, and cmd_ready = 1 after release.
